decade_step_driver: RTL and testbench
=====================================

Name: decade_step_driver

Overview:
- Synchronous driver for a chain of asynchronous up/down decade counter stages.
- Generates the active-low INC/DEC step strobes the chain consumes, either from manual step requests or from a prescaled auto-step tick.
- Issues counter-clear pulses and watches the chain's active-low CARRY/BORROW outputs to flag timer expiry and overflow.
- Sits between the timer control logic and the counter chain.

Parameters:
- PRESC, 50000, CLK cycles per auto-step tick; must be > PW+GAP+2 (elaboration-time check).
- PW, 4, strobe/clear low-or-high width in CLK cycles; must be >= 3 to cover synchronizer latency.
- GAP, 4, minimum idle (both strobes high) cycles after each strobe, for counter ripple settling.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- CLR_N  in  1  reset, asynchronous, active-low.
- RUN  in  1  level; enables prescaled auto-stepping.
- DIR  in  1  0 = up (INC), 1 = down (DEC); sampled when a step is accepted.
- STEP  in  1  single-cycle manual step request.
- LOAD_CLR  in  1  single-cycle request to clear the counter chain and the flags.
- CARRY_N  in  1  chain carry, active-low, asynchronous to CLK.
- BORROW_N  in  1  chain borrow, active-low, asynchronous to CLK.
- INC_N  out  1  increment strobe to the chain, active-low.
- DEC_N  out  1  decrement strobe to the chain, active-low.
- CNT_CLR  out  1  clear to the chain, active-high.
- BUSY  out  1  high while a strobe, clear or gap is in progress.
- EXPIRED  out  1  sticky; down-step wrapped from 0.
- OVF  out  1  sticky; up-step wrapped from max.

Behaviour:
- Reset (CLR_N=0):
  - INC_N=1, DEC_N=1, BUSY=0, EXPIRED=0, OVF=0, prescaler=0, state IDLE, synchronizers=1, no pending requests.
  - CNT_CLR=1 during reset; it deasserts on the first CLK edge after CLR_N rises.
  - This guarantees the chain is cleared even when reset releases a strobe mid-pulse, since a strobe rising edge toggles the chain.
- Synchronizers: CARRY_N and BORROW_N each pass through a 2-FF synchronizer.
- Prescaler:
  - Counts 0..PRESC-1 while RUN=1. Holds while RUN=0. Reset to 0 by LOAD_CLR.
  - At terminal count it raises an auto-tick request, which is held pending (1 deep) until accepted. A further tick while one is pending is dropped.
  - Auto-ticks are suppressed while EXPIRED=1 (down) or OVF=1 (up).
  - Manual STEP is never suppressed.
- Requests:
  - STEP arriving while BUSY is ignored.
  - LOAD_CLR arriving while BUSY is latched pending.
  - Priority in IDLE: pending LOAD_CLR > STEP > auto-tick.
  - If LOAD_CLR and a step are both present in the same IDLE cycle, the step and any pending tick are discarded.
- FSM states: IDLE, PULSE, GAP, CLRP.
  - IDLE: a step accepted in cycle t latches DIR and enters PULSE at t+1. A clear enters CLRP at t+1.
  - PULSE: the selected strobe (INC_N for DIR=0, DEC_N for DIR=1) is low for exactly PW cycles, then the state goes to GAP. Only one strobe is ever low.
  - In the last PULSE cycle the synchronized flag is sampled:
    - DIR=1 and BORROW_N=0 sets EXPIRED.
    - DIR=0 and CARRY_N=0 sets OVF.
  - CLRP: CNT_CLR=1 for PW cycles. Clears EXPIRED, OVF and the pending tick, then goes to GAP.
  - GAP: both strobes high and CNT_CLR=0 for GAP cycles, then IDLE.
- BUSY is high in PULSE, GAP and CLRP. One step occupies exactly PW+GAP cycles.
- DIR changes during a step have no effect on that step.
- A flag set while it is already 1 stays 1.

Optional Feature:
- Macro: EXPIRE_CLR_EN.
- Defined: when a PULSE sets EXPIRED or OVF, the FSM goes PULSE -> GAP -> CLRP -> GAP -> IDLE.
  - The chain is forced to 0 instead of wrapping.
  - In this CLRP only, the flag that was just set is kept.
- Undefined: no automatic clear. The chain is left wrapped (all 9s after expiry, 0 after overflow) until LOAD_CLR.

Test Plan:
- Bench setup: PRESC=20, PW=4, GAP=4, two cascaded decade-counter models.
- Reset: hold CLR_N=0, then release -> CNT_CLR=1 until the first CLK edge, chain reads 00, INC_N=DEC_N=1, BUSY=0, flags 0.
- Manual up: 12 STEP pulses at DIR=0, each after BUSY=0 -> each INC_N low exactly 4 cycles, BUSY high 8 cycles, chain reads 12, DEC_N stays 1.
- Auto down from 03: RUN=1, DIR=1 -> a DEC_N strobe every 20 cycles. The 4th strobe sets EXPIRED and auto-stepping stops.
  - EXPIRE_CLR_EN undefined: chain reads 99.
  - EXPIRE_CLR_EN defined: chain reads 00 and EXPIRED stays 1.
- Overflow: from 99, STEP at DIR=0 -> OVF=1, chain reads 00. A subsequent LOAD_CLR -> CNT_CLR high 4 cycles, OVF=0.
- Collisions: STEP pulsed mid-PULSE -> ignored, exactly one strobe. LOAD_CLR pulsed mid-PULSE -> CLRP runs immediately after that step's GAP. LOAD_CLR and STEP in the same IDLE cycle -> clear only, no strobe.
- Reset mid-PULSE: assert CLR_N=0 while DEC_N is low -> DEC_N goes 1 asynchronously, CNT_CLR=1 during reset, chain reads 00 after release, no flags set.

Source files
------------

// File: rtl/decade_step_driver.sv
// ---------------------------------------------------------------------------
// decade_step_driver
//
// Synchronous driver for a chain of asynchronous up/down decade counters.
// It turns manual step requests or a prescaled auto-step tick into
// active-low INC/DEC strobes. It also issues counter-clear pulses. The
// chain's active-low CARRY/BORROW outputs are watched to flag timer expiry
// (down-wrap from 0) and overflow (up-wrap from max).
//
// Parameters:
//   PRESC  CLK cycles per auto-step tick (must exceed PW+GAP+2)
//   PW     strobe / clear width in CLK cycles (>= 3, covers sync latency)
//   GAP    idle cycles after every strobe or clear, for ripple settling
//
// Ports:
//   CLK       system clock, rising edge
//   CLR_N     asynchronous active-low reset
//   RUN       level, enables prescaled auto-stepping
//   DIR       0 = up (INC_N), 1 = down (DEC_N), captured when a step starts
//   STEP      single-cycle manual step request (ignored while BUSY)
//   LOAD_CLR  single-cycle clear request (held pending while BUSY)
//   CARRY_N   chain carry, active-low, asynchronous
//   BORROW_N  chain borrow, active-low, asynchronous
//   INC_N     increment strobe to the chain, active-low
//   DEC_N     decrement strobe to the chain, active-low
//   CNT_CLR   clear to the chain, active-high
//   BUSY      strobe, clear or gap in progress
//   EXPIRED   sticky, a down-step wrapped from 0
//   OVF       sticky, an up-step wrapped from max
//
// Build option:
//   EXPIRE_CLR_EN  when defined, a step that sets EXPIRED or OVF is
//                  followed by an automatic chain clear. The flag that was
//                  just set survives that clear.
// ---------------------------------------------------------------------------
module decade_step_driver #(
  parameter int PRESC = 50000,
  parameter int PW    = 4,
  parameter int GAP   = 4
) (
  input  logic CLK,
  input  logic CLR_N,
  input  logic RUN,
  input  logic DIR,
  input  logic STEP,
  input  logic LOAD_CLR,
  input  logic CARRY_N,
  input  logic BORROW_N,
  output logic INC_N,
  output logic DEC_N,
  output logic CNT_CLR,
  output logic BUSY,
  output logic EXPIRED,
  output logic OVF
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_CLRP  = 2'd3;

  localparam int CNTMAX = (PW > GAP) ? PW : GAP;
  localparam int CW     = $clog2(CNTMAX + 1);
  localparam int PSW    = (PRESC > 1) ? $clog2(PRESC) : 1;

  localparam logic [CW-1:0]  PW_LAST    = CW'(PW - 1);
  localparam logic [CW-1:0]  GAP_LAST   = CW'(GAP - 1);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(PRESC - 1);

  generate
    if (PRESC <= PW + GAP + 2) begin : g_bad_presc
      $error("decade_step_driver: PRESC must exceed PW+GAP+2");
    end
    if (PW < 3) begin : g_bad_pw
      $error("decade_step_driver: PW must be at least 3");
    end
  endgenerate

  logic [1:0]     state, state_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           dir_q, dir_nx;
  logic           carry_m, carry_s, borrow_m, borrow_s;
  logic [PSW-1:0] presc;
  logic           tick_pend, clr_pend;
  logic           clr_req, auto_sup, tick_ok, presc_term;
  logic           start_step, start_clr, enter_clrp, flag_hit;
`ifdef EXPIRE_CLR_EN
  logic           auto_clr, keep_exp;
`endif

  // CARRY_N / BORROW_N come straight from the ripple chain, so each one
  // gets a plain 2-FF synchronizer. Both idle high.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      carry_m  <= 1'b1;
      carry_s  <= 1'b1;
      borrow_m <= 1'b1;
      borrow_s <= 1'b1;
    end else begin
      carry_m  <= CARRY_N;
      carry_s  <= carry_m;
      borrow_m <= BORROW_N;
      borrow_s <= borrow_m;
    end
  end

  // Next-state logic. In IDLE, a clear outranks a step, and a step
  // outranks an auto tick. The count register times PULSE, CLRP and GAP.
  always_comb begin
    clr_req    = LOAD_CLR | clr_pend;
    auto_sup   = DIR ? EXPIRED : OVF;
    tick_ok    = tick_pend & ~auto_sup;
    presc_term = RUN & ~LOAD_CLR & (presc == PRESC_LAST);
    // The synchronized flag has settled by the last strobe cycle, because
    // PW covers the synchronizer latency.
    flag_hit   = (state == S_PULSE) && (cnt == PW_LAST) &&
                 (dir_q ? ~borrow_s : ~carry_s);
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    start_step = 1'b0;
    start_clr  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (clr_req) begin
          state_nx  = S_CLRP;
          start_clr = 1'b1;
        end else if (STEP | tick_ok) begin
          state_nx   = S_PULSE;
          start_step = 1'b1;
        end
      end
      S_PULSE, S_CLRP: begin
        if (cnt == PW_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
`ifdef EXPIRE_CLR_EN
          state_nx = auto_clr ? S_CLRP : S_IDLE;
`else
          state_nx = S_IDLE;
`endif
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
    enter_clrp = (state_nx == S_CLRP) && (state != S_CLRP);
    dir_nx     = start_step ? DIR : dir_q;
  end

  // Sequential state, request bookkeeping and flags. The outputs are
  // registered from the next state, which keeps them glitch-free toward
  // the asynchronous chain. CNT_CLR resets high, so the chain is cleared
  // even when reset cuts a strobe short.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dir_q     <= 1'b0;
      presc     <= '0;
      tick_pend <= 1'b0;
      clr_pend  <= 1'b0;
      EXPIRED   <= 1'b0;
      OVF       <= 1'b0;
      INC_N     <= 1'b1;
      DEC_N     <= 1'b1;
      CNT_CLR   <= 1'b1;
      BUSY      <= 1'b0;
`ifdef EXPIRE_CLR_EN
      auto_clr  <= 1'b0;
      keep_exp  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      dir_q <= dir_nx;

      if (LOAD_CLR)
        presc <= '0;
      else if (RUN)
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;

      // The tick queue is one deep. A tick that arrives while one is
      // already pending is dropped.
      if (enter_clrp)
        tick_pend <= 1'b0;
      else if (presc_term & ~auto_sup)
        tick_pend <= 1'b1;
      else if (start_step & ~STEP)
        tick_pend <= 1'b0;

      if (start_clr)
        clr_pend <= 1'b0;
      else if (LOAD_CLR)
        clr_pend <= 1'b1;

      if (enter_clrp) begin
`ifdef EXPIRE_CLR_EN
        if (auto_clr) begin
          EXPIRED <= EXPIRED & keep_exp;
          OVF     <= OVF & ~keep_exp;
        end else begin
          EXPIRED <= 1'b0;
          OVF     <= 1'b0;
        end
`else
        EXPIRED <= 1'b0;
        OVF     <= 1'b0;
`endif
      end else if (flag_hit) begin
        if (dir_q)
          EXPIRED <= 1'b1;
        else
          OVF <= 1'b1;
      end

`ifdef EXPIRE_CLR_EN
      if (flag_hit) begin
        auto_clr <= 1'b1;
        keep_exp <= dir_q;
      end else if (enter_clrp) begin
        auto_clr <= 1'b0;
      end
`endif

      INC_N   <= ~((state_nx == S_PULSE) & ~dir_nx);
      DEC_N   <= ~((state_nx == S_PULSE) & dir_nx);
      CNT_CLR <= (state_nx == S_CLRP);
      BUSY    <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_decade_step_driver.sv
// ---------------------------------------------------------------------------
// tb_decade_step_driver
//
// Bench for decade_step_driver with PRESC=20, PW=4, GAP=4. The bench drives
// two cascaded behavioural decade counters (units, tens). Each counter
// steps on a strobe rising edge and is cleared by CNT_CLR as a level.
// CARRY_N / BORROW_N are decoded from the chain.
// ---------------------------------------------------------------------------
module tb_decade_step_driver;

  localparam int PRESC = 20;
  localparam int PW    = 4;
  localparam int GAP   = 4;

  logic CLK = 1'b0;
  logic CLR_N = 1'b1;
  logic RUN = 1'b0;
  logic DIR = 1'b0;
  logic STEP = 1'b0;
  logic LOAD_CLR = 1'b0;
  logic CARRY_N, BORROW_N;
  logic INC_N, DEC_N, CNT_CLR, BUSY, EXPIRED, OVF;

  int total = 0;
  int bad = 0;

  // Start from a non-zero chain value so the reset clear is observable.
  int units = 5;
  int tens = 5;
  logic incPrevM = 1'b1;
  logic decPrevM = 1'b1;

  int incLow, decLow, clrHigh, busyHigh;
  int incFalls, decFalls, clrRises, bothLow, clrFirst, cyc;
  int decFallAt[8];
  logic incP, decP, clrP;

  typedef struct {
    string name;
    int    reps;
    logic  doStep;
    logic  doClr;
    logic  dir;
    int    expChain;
    int    expInc;
    int    expDec;
    int    expClr;
    int    expBusy;
    int    expOvf;
    int    expExp;
  } vec_t;

  vec_t vecs[6];

  always #5 CLK = ~CLK;

  decade_step_driver #(.PRESC(PRESC), .PW(PW), .GAP(GAP)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .RUN(RUN), .DIR(DIR), .STEP(STEP),
    .LOAD_CLR(LOAD_CLR), .CARRY_N(CARRY_N), .BORROW_N(BORROW_N),
    .INC_N(INC_N), .DEC_N(DEC_N), .CNT_CLR(CNT_CLR), .BUSY(BUSY),
    .EXPIRED(EXPIRED), .OVF(OVF)
  );

  // Two cascaded decade counters. The units digit ripples into tens on
  // wrap. A strobe rising edge steps the chain, and CNT_CLR dominates.
  always @(INC_N or DEC_N or CNT_CLR) begin
    if (CNT_CLR === 1'b1) begin
      units = 0;
      tens  = 0;
    end else begin
      if (INC_N === 1'b1 && incPrevM === 1'b0) begin
        if (units == 9) begin
          units = 0;
          tens  = (tens == 9) ? 0 : tens + 1;
        end else begin
          units = units + 1;
        end
      end
      if (DEC_N === 1'b1 && decPrevM === 1'b0) begin
        if (units == 0) begin
          units = 9;
          tens  = (tens == 0) ? 9 : tens - 1;
        end else begin
          units = units - 1;
        end
      end
    end
    incPrevM = INC_N;
    decPrevM = DEC_N;
  end

  assign CARRY_N  = ~((INC_N == 1'b0) && (units == 9) && (tens == 9));
  assign BORROW_N = ~((DEC_N == 1'b0) && (units == 0) && (tens == 0));

  function automatic int chainVal();
    return tens * 10 + units;
  endfunction

  function automatic vec_t mk(string n, int reps, logic st, logic cl, logic d,
                              int ch, int ei, int ed, int ec, int eb,
                              int eo, int ee);
    vec_t v;
    v.name = n; v.reps = reps; v.doStep = st; v.doClr = cl; v.dir = d;
    v.expChain = ch; v.expInc = ei; v.expDec = ed; v.expClr = ec;
    v.expBusy = eb; v.expOvf = eo; v.expExp = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic resetCounters();
    incLow = 0; decLow = 0; clrHigh = 0; busyHigh = 0;
    incFalls = 0; decFalls = 0; clrRises = 0; bothLow = 0;
    clrFirst = -1; cyc = 0;
    for (int i = 0; i < 8; i++) decFallAt[i] = 0;
    incP = INC_N; decP = DEC_N; clrP = CNT_CLR;
  endtask

  // Wait for the next falling edge, then record what the outputs show.
  task automatic sampleCycle();
    @(negedge CLK);
    if (!INC_N) incLow++;
    if (!DEC_N) decLow++;
    if (CNT_CLR) clrHigh++;
    if (BUSY) busyHigh++;
    if (!INC_N && !DEC_N) bothLow++;
    if (!INC_N && incP) incFalls++;
    if (!DEC_N && decP) begin
      if (decFalls < 8) decFallAt[decFalls] = cyc;
      decFalls++;
    end
    if (CNT_CLR && !clrP) begin
      clrRises++;
      if (clrFirst < 0) clrFirst = cyc;
    end
    incP = INC_N; decP = DEC_N; clrP = CNT_CLR;
    cyc++;
  endtask

  // Issue a request in window cycle 0, plus an optional second request at
  // cycle injAt. Every cycle of the fixed window is sampled. Call this
  // just after a falling edge.
  task automatic applyStimulus(input logic s, input logic l, input logic d,
                               input int injAt, input logic injS,
                               input logic injL, input int cycles);
    resetCounters();
    DIR = d;
    for (int k = 0; k < cycles; k++) begin
      STEP     = ((k == 0) && s) || ((k == injAt) && injS);
      LOAD_CLR = ((k == 0) && l) || ((k == injAt) && injL);
      sampleCycle();
    end
    STEP = 1'b0;
    LOAD_CLR = 1'b0;
  endtask

  task automatic runRows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        applyStimulus(vecs[i].doStep, vecs[i].doClr, vecs[i].dir, -1, 1'b0, 1'b0, 20);
        checkOutput({vecs[i].name, ".incLow"}, incLow, vecs[i].expInc);
        checkOutput({vecs[i].name, ".decLow"}, decLow, vecs[i].expDec);
        checkOutput({vecs[i].name, ".clrHigh"}, clrHigh, vecs[i].expClr);
        checkOutput({vecs[i].name, ".busy"}, busyHigh, vecs[i].expBusy);
        checkOutput({vecs[i].name, ".bothLow"}, bothLow, 0);
      end
      checkOutput({vecs[i].name, ".chain"}, chainVal(), vecs[i].expChain);
      checkOutput({vecs[i].name, ".ovf"}, OVF, vecs[i].expOvf);
      checkOutput({vecs[i].name, ".expired"}, EXPIRED, vecs[i].expExp);
    end
  endtask

  initial begin
    vecs[0] = mk("up12",   12, 1'b1, 1'b0, 1'b0, 12, 4, 0, 0, 8, 0, 0);
    vecs[1] = mk("down9",   9, 1'b1, 1'b0, 1'b1,  3, 0, 4, 0, 8, 0, 0);
    vecs[2] = mk("clear1",  1, 1'b0, 1'b1, 1'b0,  0, 0, 0, 4, 8, 0, 0);
    vecs[3] = mk("up99",   99, 1'b1, 1'b0, 1'b0, 99, 4, 0, 0, 8, 0, 0);
`ifdef EXPIRE_CLR_EN
    vecs[4] = mk("ovf",     1, 1'b1, 1'b0, 1'b0,  0, 4, 0, 4, 16, 1, 0);
`else
    vecs[4] = mk("ovf",     1, 1'b1, 1'b0, 1'b0,  0, 4, 0, 0, 8, 1, 0);
`endif
    vecs[5] = mk("clear2",  1, 1'b0, 1'b1, 1'b0,  0, 0, 0, 4, 8, 0, 0);

    // Reset: hold reset and check the idle outputs, with CNT_CLR held high.
    #1 CLR_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst.cntClr", CNT_CLR, 1);
    checkOutput("rst.incN", INC_N, 1);
    checkOutput("rst.decN", DEC_N, 1);
    checkOutput("rst.busy", BUSY, 0);
    checkOutput("rst.expired", EXPIRED, 0);
    checkOutput("rst.ovf", OVF, 0);
    #2 CLR_N = 1'b1;
    #1 checkOutput("rst.cntClrHeld", CNT_CLR, 1);
    @(negedge CLK);
    checkOutput("rst.cntClrDrop", CNT_CLR, 0);
    checkOutput("rst.chain", chainVal(), 0);

    runRows(0, 1);

    // Auto-stepping down from 03. A strobe follows every prescaler period,
    // and the fourth strobe wraps the chain and stops auto-stepping.
    RUN = 1'b1;
    DIR = 1'b1;
    resetCounters();
    for (int k = 0; k < 200; k++) sampleCycle();
    RUN = 1'b0;
    checkOutput("auto.decStrobes", decFalls, 4);
    checkOutput("auto.incStrobes", incFalls, 0);
    checkOutput("auto.period01", decFallAt[1] - decFallAt[0], PRESC);
    checkOutput("auto.period23", decFallAt[3] - decFallAt[2], PRESC);
    checkOutput("auto.expired", EXPIRED, 1);
    checkOutput("auto.ovf", OVF, 0);
`ifdef EXPIRE_CLR_EN
    checkOutput("auto.chain", chainVal(), 0);
`else
    checkOutput("auto.chain", chainVal(), 99);
`endif

    runRows(2, 5);

    // A STEP that arrives mid-pulse is ignored.
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b0, 20);
    checkOutput("stepMid.incStrobes", incFalls, 1);
    checkOutput("stepMid.incLow", incLow, PW);
    checkOutput("stepMid.chain", chainVal(), 1);

    // A LOAD_CLR and a STEP in the same idle cycle produce the clear only.
    applyStimulus(1'b1, 1'b1, 1'b0, -1, 1'b0, 1'b0, 20);
    checkOutput("clrStep.incStrobes", incFalls, 0);
    checkOutput("clrStep.decStrobes", decFalls, 0);
    checkOutput("clrStep.clrPulses", clrRises, 1);
    checkOutput("clrStep.clrHigh", clrHigh, PW);
    checkOutput("clrStep.chain", chainVal(), 0);

    // A LOAD_CLR mid-pulse is held. It runs after the step's gap and one
    // idle cycle.
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 24);
    checkOutput("clrMid.incStrobes", incFalls, 1);
    checkOutput("clrMid.clrPulses", clrRises, 1);
    checkOutput("clrMid.clrStart", clrFirst, PW + GAP + 1);
    checkOutput("clrMid.busy", busyHigh, 2 * (PW + GAP));
    checkOutput("clrMid.chain", chainVal(), 0);

    // Reset during a DEC pulse: the strobe is released asynchronously, the
    // chain is cleared and no flag is left behind.
    applyStimulus(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 20);
    checkOutput("rstMid.preChain", chainVal(), 1);
    DIR = 1'b1;
    STEP = 1'b1;
    sampleCycle();
    STEP = 1'b0;
    checkOutput("rstMid.decLow", DEC_N, 0);
    sampleCycle();
    #2 CLR_N = 1'b0;
    #1;
    checkOutput("rstMid.decN", DEC_N, 1);
    checkOutput("rstMid.cntClr", CNT_CLR, 1);
    checkOutput("rstMid.busy", BUSY, 0);
    checkOutput("rstMid.chainInRst", chainVal(), 0);
    @(negedge CLK);
    #2 CLR_N = 1'b1;
    @(negedge CLK);
    checkOutput("rstMid.cntClrDrop", CNT_CLR, 0);
    checkOutput("rstMid.incN", INC_N, 1);
    checkOutput("rstMid.decNAfter", DEC_N, 1);
    checkOutput("rstMid.expired", EXPIRED, 0);
    checkOutput("rstMid.ovf", OVF, 0);
    checkOutput("rstMid.chain", chainVal(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
